// File: rtl/sfx_pkg.sv
// Shared types and the default tone table for the sound-effect engine.
package sfx_pkg;

    typedef struct packed {
        logic [15:0] half_period;
        logic [15:0] duration;
    } tone_t;

    typedef enum logic [2:0] {
        EV_WALL   = 3'd0,
        EV_PADDLE = 3'd1,
        EV_POINT  = 3'd2,
        EV_LVL_UP = 3'd3,
        EV_WIN    = 3'd4
    } event_e;

    // half period and duration, both in frames
    localparam tone_t TONE_TABLE [8] = '{
        '{16'd24, 16'd2400},
        '{16'd48, 16'd2400},
        '{16'd96, 16'd9600},
        '{16'd12, 16'd9600},
        '{16'd32, 16'd24000},
        '{16'd0,  16'd0},
        '{16'd0,  16'd0},
        '{16'd0,  16'd0}
    };

    function automatic logic tone_ok(input tone_t t);
        return (t.half_period != 16'd0) && (t.duration != 16'd0);
    endfunction

endpackage

// File: rtl/sfx_tone_gen_if.sv
// WM8731 DAC-side pins: MCLK, bit clock, LR clock and serial data.
interface sfx_tone_gen_if;

    logic aud_xck;
    logic aud_bclk;
    logic aud_daclrck;
    logic aud_dacdat;

    modport master (
        output aud_xck,
        output aud_bclk,
        output aud_daclrck,
        output aud_dacdat
    );

    modport slave (
        input aud_xck,
        input aud_bclk,
        input aud_daclrck,
        input aud_dacdat
    );

endinterface

// File: rtl/wm8731_dac_ser.sv
// Left-justified serialiser: frame counter, BCLK/LRCK/DAT and the
// per-frame sample latch.
module wm8731_dac_ser #(
    parameter int SAMPLE_W       = 16,
    parameter int CLK_PER_BCLK   = 16,
    parameter int BCLKS_PER_HALF = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                tick,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat
);

    localparam int HALF  = BCLKS_PER_HALF * CLK_PER_BCLK;
    localparam int FRAME = 2 * HALF;
    localparam int FW    = $clog2(FRAME);
    localparam int PW    = $clog2(CLK_PER_BCLK);
    localparam int KW    = (BCLKS_PER_HALF > 1) ? $clog2(BCLKS_PER_HALF) : 1;

    logic [FW-1:0]       fcnt;
    logic [PW-1:0]       ph;
    logic [KW-1:0]       k;
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] sh;
    logic                dbit;

    assign tick = (fcnt == FW'(FRAME - 1));

    // bit 0 goes out on the same edge the sample is latched
    always_comb begin
        cur  = (fcnt == '0) ? sample : smp;
        sh   = cur << k;
        dbit = sh[SAMPLE_W-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt        <= '0;
            ph          <= '0;
            k           <= '0;
            smp         <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
        end else begin
            fcnt <= tick ? '0 : fcnt + 1'b1;
            ph   <= (ph == PW'(CLK_PER_BCLK - 1)) ? '0 : ph + 1'b1;
            if (ph == PW'(CLK_PER_BCLK - 1)) begin
                k <= (k == KW'(BCLKS_PER_HALF - 1)) ? '0 : k + 1'b1;
            end
            if (fcnt == '0) begin
                smp <= sample;
            end
            aud_bclk    <= (ph >= PW'(CLK_PER_BCLK / 2));
            aud_daclrck <= (fcnt < FW'(HALF));
            if (ph == '0) begin
                aud_dacdat <= dbit;
            end
        end
    end

endmodule

// File: rtl/sfx_tone_gen.sv
// Prioritised square-wave sound-effect engine feeding a WM8731 DAC.
// Define SFX_DECAY_EN to step the amplitude down each quarter of a tone.
module sfx_tone_gen
    import sfx_pkg::*;
#(
    parameter int                  N_EVENTS       = 5,
    parameter int                  SAMPLE_W       = 16,
    parameter int                  CLK_PER_BCLK   = 16,
    parameter int                  BCLKS_PER_HALF = 32,
    parameter logic [SAMPLE_W-1:0] AMPLITUDE      = SAMPLE_W'(16'h2000),
    parameter tone_t               TONES [8]      = TONE_TABLE,
    localparam int ID_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_EVENTS-1:0] trig,
    input  logic                mute,
    sfx_tone_gen_if.master      aud,
    output logic                busy,
    output logic [ID_W-1:0]     active_id
);

    logic [2:0]          h;
    logic [2:0]          act3;
    logic                hit;
    logic                load;
    logic                tick;
    tone_t               th;
    tone_t               ta;
    logic [15:0]         dur_cnt;
    logic [15:0]         hp_cnt;
    logic                level;
    logic                xdiv;
    logic [SAMPLE_W-1:0] mag;
    logic [SAMPLE_W-1:0] sample;

    always_comb begin
        h   = 3'd0;
        hit = 1'b0;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (trig[i]) begin
                h   = 3'(i);
                hit = 1'b1;
            end
        end
    end

    assign act3 = 3'(active_id);
    assign th   = TONES[h];
    assign ta   = TONES[act3];
    assign load = hit && tone_ok(th) && (!busy || h >= act3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            active_id <= '0;
            dur_cnt   <= '0;
            hp_cnt    <= '0;
            level     <= 1'b1;
        end else if (load) begin
            busy      <= 1'b1;
            active_id <= ID_W'(h);
            dur_cnt   <= th.duration;
            hp_cnt    <= '0;
            level     <= 1'b1;
        end else if (tick && busy) begin
            if (hp_cnt == ta.half_period - 16'd1) begin
                level  <= ~level;
                hp_cnt <= '0;
            end else begin
                hp_cnt <= hp_cnt + 16'd1;
            end
            dur_cnt <= dur_cnt - 16'd1;
            if (dur_cnt == 16'd1) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef SFX_DECAY_EN
    logic [15:0] b1;
    logic [15:0] b2;
    logic [15:0] b3;
    logic [1:0]  q;

    // quarter boundaries snapshot at load so retriggers rescale them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b1 <= '0;
            b2 <= '0;
            b3 <= '0;
        end else if (load) begin
            b1 <= 16'((32'(th.duration) * 32'd3) >> 2);
            b2 <= th.duration >> 1;
            b3 <= th.duration >> 2;
        end
    end

    always_comb begin
        q = 2'd0;
        if (dur_cnt <= b3) begin
            q = 2'd3;
        end else if (dur_cnt <= b2) begin
            q = 2'd2;
        end else if (dur_cnt <= b1) begin
            q = 2'd1;
        end
    end

    assign mag = AMPLITUDE >> q;
`else
    assign mag = AMPLITUDE;
`endif

    assign sample = (busy && !mute) ? (level ? mag : -mag) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xdiv        <= 1'b0;
            aud.aud_xck <= 1'b0;
        end else begin
            xdiv <= ~xdiv;
            if (xdiv) begin
                aud.aud_xck <= ~aud.aud_xck;
            end
        end
    end

    wm8731_dac_ser #(
        .SAMPLE_W       (SAMPLE_W),
        .CLK_PER_BCLK   (CLK_PER_BCLK),
        .BCLKS_PER_HALF (BCLKS_PER_HALF)
    ) u_ser (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample      (sample),
        .tick        (tick),
        .aud_bclk    (aud.aud_bclk),
        .aud_daclrck (aud.aud_daclrck),
        .aud_dacdat  (aud.aud_dacdat)
    );

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Bench for sfx_tone_gen: frame-level reference model feeding a sample
// scoreboard, plus directed arbitration, timing and reset steps.
module tb_sfx_tone_gen;
    import sfx_pkg::*;

    localparam int CPB   = 4;
    localparam int BPH   = 20;
    localparam int SW    = 16;
    localparam int FRAME = 2 * BPH * CPB;
    localparam logic [15:0] AMP = 16'h2000;

    // short tones keep the run small: {half_period, duration}
    localparam tone_t TB_TONES [8] = '{
        '{16'd2, 16'd8},
        '{16'd3, 16'd6},
        '{16'd2, 16'd12},
        '{16'd1, 16'd6},
        '{16'd3, 16'd16},
        '{16'd0, 16'd0},
        '{16'd0, 16'd0},
        '{16'd0, 16'd0}
    };

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mute  = 1'b0;
    logic [4:0] trig  = 5'd0;
    logic       busy;
    logic [2:0] active_id;

    sfx_tone_gen_if aud ();

    sfx_tone_gen #(
        .N_EVENTS       (5),
        .SAMPLE_W       (SW),
        .CLK_PER_BCLK   (CPB),
        .BCLKS_PER_HALF (BPH),
        .AMPLITUDE      (AMP),
        .TONES          (TB_TONES)
    ) dut (
        .clk       (clk),
        .reset_n   (rst_n),
        .trig      (trig),
        .mute      (mute),
        .aud       (aud),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_fcnt;
    logic        m_busy;
    logic        m_level;
    int          m_id;
    int          m_dur;
    int          m_hp;
    logic [15:0] exp_q [$];

    function automatic int top_bit(input logic [4:0] t);
        int r = -1;
        for (int i = 0; i < 5; i++) if (t[i]) r = i;
        return r;
    endfunction

    function automatic logic can_load(input logic [4:0] t, input logic b,
                                      input int id);
        int hb = top_bit(t);
        if (hb < 0) return 1'b0;
        if (TB_TONES[hb].duration == 0 || TB_TONES[hb].half_period == 0)
            return 1'b0;
        return !b || hb >= id;
    endfunction

    function automatic logic [15:0] model_smp();
        logic [15:0] m = AMP;
`ifdef SFX_DECAY_EN
        int d = int'(TB_TONES[m_id].duration);
        if (m_dur <= d / 4) m = AMP >> 3;
        else if (m_dur <= d / 2) m = AMP >> 2;
        else if (m_dur <= (d * 3) / 4) m = AMP >> 1;
`endif
        if (!m_busy || mute) return 16'h0000;
        return m_level ? m : -m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fcnt  <= 0;
            m_busy  <= 1'b0;
            m_level <= 1'b1;
            m_id    <= 0;
            m_dur   <= 0;
            m_hp    <= 0;
            exp_q.delete();
        end else begin
            if (m_fcnt == 0) exp_q.push_back(model_smp());
            if (can_load(trig, m_busy, m_id)) begin
                m_id    <= top_bit(trig);
                m_busy  <= 1'b1;
                m_dur   <= int'(TB_TONES[top_bit(trig)].duration);
                m_hp    <= 0;
                m_level <= 1'b1;
            end else if (m_fcnt == FRAME - 1 && m_busy) begin
                if (m_hp == int'(TB_TONES[m_id].half_period) - 1) begin
                    m_level <= !m_level;
                    m_hp    <= 0;
                end else begin
                    m_hp <= m_hp + 1;
                end
                m_dur <= m_dur - 1;
                if (m_dur == 1) m_busy <= 1'b0;
            end
            m_fcnt <= (m_fcnt == FRAME - 1) ? 0 : m_fcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_model", busy, m_busy);
            chk("id_model", active_id, m_id);
        end
    end

    // ---------------- serial deserialiser / scoreboard ----------------
    logic        prev_lrck;
    logic        prev_bclk;
    logic        in_left;
    logic        have_left;
    logic [31:0] sr;
    logic [15:0] cur_exp;

    function automatic logic [31:0] exp_word(input logic [15:0] s);
        return 32'(s) << (BPH - SW);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_lrck <= 1'b0;
            prev_bclk <= 1'b0;
            in_left   <= 1'b0;
            have_left <= 1'b0;
            sr        <= '0;
            cur_exp   <= '0;
        end else begin
            prev_lrck <= aud.aud_daclrck;
            prev_bclk <= aud.aud_bclk;
            if (aud.aud_daclrck && !prev_lrck) begin
                if (have_left) chk("right_word", sr, exp_word(cur_exp));
                in_left   <= 1'b1;
                have_left <= 1'b0;
                sr        <= '0;
            end else if (!aud.aud_daclrck && prev_lrck) begin
                if (in_left) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        chk("left_word", sr, exp_word(exp_q[0]));
                        cur_exp <= exp_q[0];
                        exp_q.delete(0);
                        have_left <= 1'b1;
                    end
                end
                in_left <= 1'b0;
                sr      <= '0;
            end else if (aud.aud_bclk && !prev_bclk) begin
                sr <= {sr[30:0], aud.aud_dacdat};
            end
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic pin(input int sel);
        case (sel)
            0:       return aud.aud_daclrck;
            1:       return aud.aud_bclk;
            default: return aud.aud_xck;
        endcase
    endfunction

    task automatic meas(input int sel, output int per);
        int   g = 0;
        logic p = pin(sel);
        logic c = p;
        while (g < 1000) begin
            @(negedge clk);
            g++;
            c = pin(sel);
            if (!p && c) break;
            p = c;
        end
        p   = c;
        per = 0;
        while (per < 1000) begin
            @(negedge clk);
            per++;
            c = pin(sel);
            if (!p && c) break;
            p = c;
        end
    endtask

    task automatic wait_phase(input int v);
        int g = 0;
        while (m_fcnt != v && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (g >= 400) chk("phase_wait", m_fcnt, v);
    endtask

    task automatic pulse(input logic [4:0] t);
        trig = t;
        @(negedge clk);
        trig = 5'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    int p;
    int n;
    int ones;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_id", active_id, 0);
        chk("rst_dat", aud.aud_dacdat, 0);
        chk("rst_lrck", aud.aud_daclrck, 0);
        chk("rst_bclk", aud.aud_bclk, 0);
        chk("rst_xck", aud.aud_xck, 0);
        rst_n = 1'b1;

        meas(0, p);
        chk("lrck_period", p, FRAME);
        meas(1, p);
        chk("bclk_period", p, CPB);
        meas(2, p);
        chk("xck_period", p, 4);
        ones = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (aud.aud_dacdat) ones++;
        end
        chk("idle_dat", ones, 0);

        wait_phase(50);
        pulse(5'b00001);
        chk("wall_busy", busy, 1);
        chk("wall_id", active_id, 0);
        wait_idle(n);
        chk("wall_len", n, (FRAME - 1 - 50) + 7 * FRAME);

        wait_phase(30);
        pulse(5'b00001);
        repeat (2 * FRAME) @(negedge clk);
        wait_phase(70);
        pulse(5'b10000);
        chk("win_id", active_id, 4);
        chk("win_busy", busy, 1);
        n = 0;
        while (busy && n < 5000) begin
            if (n == 300) trig = 5'b00010;
            if (n == 301) trig = 5'b00000;
            @(negedge clk);
            n++;
            if (n == 310) chk("win_keep_id", active_id, 4);
        end
        chk("win_len", n, (FRAME - 1 - 70) + 15 * FRAME);
        chk("win_id_hold", active_id, 4);

        wait_phase(20);
        pulse(5'b00001);
        repeat (FRAME) @(negedge clk);
        wait_phase(FRAME - 1);
        pulse(5'b00110);
        chk("tick_id", active_id, 2);
        wait_idle(n);
        chk("tick_len", n, 12 * FRAME);

        wait_phase(40);
        pulse(5'b00010);
        repeat (2 * FRAME) @(negedge clk);
        wait_phase(40);
        pulse(5'b00010);
        chk("retrig_id", active_id, 1);
        wait_idle(n);
        chk("retrig_len", n, (FRAME - 1 - 40) + 5 * FRAME);

        wait_phase(10);
        pulse(5'b00100);
        n = 0;
        while (busy && n < 5000) begin
            if (n == 500) mute = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("mute_len", n, (FRAME - 1 - 10) + 11 * FRAME);
        mute = 1'b0;

        wait_phase(60);
        pulse(5'b10000);
        repeat (300) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_id", active_id, 0);
        chk("arst_dat", aud.aud_dacdat, 0);
        chk("arst_lrck", aud.aud_daclrck, 0);
        chk("arst_bclk", aud.aud_bclk, 0);
        chk("arst_xck", aud.aud_xck, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("lrck_restart", aud.aud_daclrck, 1);
        chk("post_rst_busy", busy, 0);
        repeat (3 * FRAME) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
